// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizes for the FIFO burst reader.
package fifo_rd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int LEN_W_DEF      = 8;
  localparam int BUF_DEPTH_DEF  = 3;

endpackage

// File: rtl/fifo_rd_out_buf.sv
// Small circular output buffer: push at tail, pop at head, occupancy count.
// Head data reads as zero while the buffer is empty.
module fifo_rd_out_buf #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 3,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [OCC_W-1:0] o_occ,
  output logic [WIDTH-1:0] o_head
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_occ  = r_occ;
  assign o_head = (r_occ != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master: drains N words from a 1-cycle-latency FIFO into a valid/ready stream.
// Optional FIFO_BURST_READER_STATS_EN adds saturating stat_words / stat_stall counters.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stall
`endif
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int CNT_W = OCC_W + 1;

  rd_state_t        r_state, w_state_nxt;
  logic [LEN_W-1:0] r_rd_left, w_rd_left_nxt;
  logic [LEN_W-1:0] r_acc_left, w_acc_left_nxt;
  logic             r_inflight;
  logic [OCC_W-1:0] w_occ;
  logic [CNT_W-1:0] w_pending;
  logic             w_pop;
  logic             w_last;

  // Words buffered plus the one possibly returning from the FIFO this cycle.
  assign w_pending  = CNT_W'(w_occ) + CNT_W'(r_inflight);
  assign fifo_rd_en = (r_state == BURST) && (r_rd_left != '0) && !fifo_empty &&
                      (w_pending < CNT_W'(BUF_DEPTH));

  assign m_valid = (w_occ != '0);
  assign w_pop   = m_valid && m_ready;
  assign w_last  = w_pop && (r_state == BURST) && (r_acc_left == LEN_W'(1));
  assign done    = w_last;
  assign busy    = (r_state == BURST);

  fifo_rd_out_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (fifo_data_out),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (m_data)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_rd_left_nxt  = r_rd_left;
    w_acc_left_nxt = r_acc_left;
    case (r_state)
      IDLE: begin
        if (start && (burst_len != '0)) begin
          w_state_nxt    = BURST;
          w_rd_left_nxt  = burst_len;
          w_acc_left_nxt = burst_len;
        end
      end
      BURST: begin
        if (fifo_rd_en) w_rd_left_nxt  = r_rd_left - 1'b1;
        if (w_pop)      w_acc_left_nxt = r_acc_left - 1'b1;
        if (w_last)     w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rd_left  <= '0;
      r_acc_left <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_left  <= w_rd_left_nxt;
      r_acc_left <= w_acc_left_nxt;
      r_inflight <= fifo_rd_en;
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] r_stat_words;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_words <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_pop && (r_stat_words != '1)) r_stat_words <= r_stat_words + 1'b1;
      if ((r_state == BURST) && (r_rd_left != '0) && fifo_empty && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_words = r_stat_words;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural 1-cycle-latency FIFO and a stream monitor.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        busy;
  logic        done;
  logic        fifo_rd_en;
  logic        fifo_empty;
  logic [15:0] fifo_data_out = 16'd0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] stat_words;
  logic [31:0] stat_stall;
`endif

  fifo_burst_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .burst_len     (burst_len),
    .busy          (busy),
    .done          (done),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready)
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    .stat_words    (stat_words),
    .stat_stall    (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural source FIFO: data appears the cycle after an accepted read.
  logic [15:0] fifo_mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= fifo_mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  // Mid-cycle monitor; all counters are cumulative and tests work on deltas.
  logic [15:0] hs_data [0:255];
  int          hs_cyc  [0:255];
  int          hs_n = 0;
  int          n_rd = 0;
  int          n_done = 0;
  int          done_at = 0;
  int          n_underflow = 0;
  int          n_hold_err = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = 16'd0;

  always @(negedge clk) begin
    if (fifo_rd_en) n_rd++;
    if (fifo_rd_en && fifo_empty) n_underflow++;
    if (m_valid && m_ready) begin
      hs_data[hs_n] = m_data;
      hs_cyc[hs_n]  = cyc;
      hs_n++;
    end
    if (done) begin
      n_done++;
      done_at = hs_n;
    end
    if (rst_n && prev_hold && (m_data != prev_data)) n_hold_err++;
    prev_hold = rst_n && m_valid && !m_ready;
    prev_data = m_data;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) step();
    check(tag, 32'(n_done != d0), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int base, input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) check(tag, 32'(hs_data[base + i]), 32'(first + 16'(i)));
  endtask

  int base_hs, base_rd, base_done, k;

  initial begin
    do_reset();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data",  32'(m_data), 32'd0);

    // 1: full-rate burst of 8
    for (int i = 1; i <= 8; i++) push(16'(i));
    base_hs = hs_n; base_rd = n_rd; base_done = n_done;
    m_ready = 1'b1;
    start = 1'b1; burst_len = 8'd8; k = cyc;
    step();
    start = 1'b0;
    wait_done("t1_done_seen", 40);
    step();
    check("t1_words",   32'(hs_n - base_hs), 32'd8);
    check_seq("t1_data", base_hs, 16'h0001, 8);
    check("t1_latency", 32'(hs_cyc[base_hs] - k), 32'd3);
    check("t1_back2back", 32'(hs_cyc[base_hs + 7] - hs_cyc[base_hs]), 32'd7);
    check("t1_rd_en",   32'(n_rd - base_rd), 32'd8);
    check("t1_done_cnt", 32'(n_done - base_done), 32'd1);
    check("t1_done_at", 32'(done_at), 32'(base_hs + 8));
    check("t1_busy",    32'(busy), 32'd0);

    // 2: backpressure fills the buffer, then drains in order
    for (int i = 1; i <= 4; i++) push(16'h0A00 + 16'(i));
    base_hs = hs_n; base_rd = n_rd; base_done = n_done;
    m_ready = 1'b0;
    start = 1'b1; burst_len = 8'd4;
    step();
    start = 1'b0;
    repeat (9) step();
    check("t2_rd_stall", 32'(n_rd - base_rd), 32'd3);
    check("t2_valid",    32'(m_valid), 32'd1);
    check("t2_head",     32'(m_data), 32'h0A01);
    check("t2_busy",     32'(busy), 32'd1);
    m_ready = 1'b1;
    wait_done("t2_done_seen", 30);
    step();
    check("t2_words",    32'(hs_n - base_hs), 32'd4);
    check_seq("t2_data", base_hs, 16'h0A01, 4);
    check("t2_hold",     32'(n_hold_err), 32'd0);

    // 3: FIFO runs dry mid-burst, refilled later
    do_reset();
    push(16'h0B01); push(16'h0B02);
    base_hs = hs_n; base_rd = n_rd; base_done = n_done;
    m_ready = 1'b1;
    start = 1'b1; burst_len = 8'd5;
    step();
    start = 1'b0;
    repeat (5) step();
    check("t3_busy_stalled", 32'(busy), 32'd1);
    check("t3_rd_stalled",   32'(n_rd - base_rd), 32'd2);
    push(16'h0B03); push(16'h0B04); push(16'h0B05);
    wait_done("t3_done_seen", 30);
    repeat (3) step();
    check("t3_words",    32'(hs_n - base_hs), 32'd5);
    check_seq("t3_data", base_hs, 16'h0B01, 5);
    check("t3_underflow", 32'(n_underflow), 32'd0);
    check("t3_done_cnt", 32'(n_done - base_done), 32'd1);
`ifdef FIFO_BURST_READER_STATS_EN
    check("t6_stat_words", stat_words, 32'd5);
    check("t6_stat_stall", stat_stall, 32'd3);
`endif

    // 4: zero-length start and start-while-busy are ignored
    base_rd = n_rd;
    start = 1'b1; burst_len = 8'd0;
    step();
    start = 1'b0;
    repeat (3) step();
    check("t4_len0_busy", 32'(busy), 32'd0);
    check("t4_len0_rd",   32'(n_rd - base_rd), 32'd0);
    push(16'h0C01); push(16'h0C02);
    base_hs = hs_n; base_rd = n_rd;
    m_ready = 1'b0;
    start = 1'b1; burst_len = 8'd2;
    step();
    burst_len = 8'd5;
    step();
    start = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    m_ready = 1'b1;
    wait_done("t4_done_seen", 30);
    repeat (3) step();
    check("t4_idle",  32'(busy), 32'd0);
    check("t4_rd_en", 32'(n_rd - base_rd), 32'd2);
    check("t4_words", 32'(hs_n - base_hs), 32'd2);
    check_seq("t4_data", base_hs, 16'h0C01, 2);

    // 5: reset mid-burst aborts silently, next burst is clean
    for (int i = 1; i <= 4; i++) push(16'h0D00 + 16'(i));
    base_hs = hs_n; base_done = n_done;
    m_ready = 1'b0;
    start = 1'b1; burst_len = 8'd4;
    step();
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_busy",  32'(busy), 32'd0);
    check("t5_done",  32'(done), 32'd0);
    check("t5_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_data",  32'(m_data), 32'd0);
    step();
    check("t5_no_done", 32'(n_done - base_done), 32'd0);
    check("t5_no_hs",   32'(hs_n - base_hs), 32'd0);
    push(16'h0E01); push(16'h0E02);
    m_ready = 1'b1;
    start = 1'b1; burst_len = 8'd3;
    step();
    start = 1'b0;
    wait_done("t5_done_seen", 30);
    step();
    check("t5_words", 32'(hs_n - base_hs), 32'd3);
    check("t5_w0", 32'(hs_data[base_hs]), 32'h0D04);
    check_seq("t5_data", base_hs + 1, 16'h0E01, 2);
    check("t5_done_cnt", 32'(n_done - base_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
